// File: rtl/ddr_cmd_pkg.sv
// Shared DDR4 command definitions: power states, decoded command codes and
// the {ras_n,cas_n,we_n} encodings used when act_n is high.
package ddr_cmd_pkg;

   typedef enum logic [1:0] {
      P_INIT   = 2'd0,
      P_ACTIVE = 2'd1,
      P_PD     = 2'd2,
      P_SR     = 2'd3
   } pwr_state_t;

   typedef enum logic [3:0] {
      CMD_DES,
      CMD_NOP,
      CMD_ACT,
      CMD_MRW,
      CMD_REF,
      CMD_PR,
      CMD_PRA,
      CMD_WR,
      CMD_WRA,
      CMD_RD,
      CMD_RDA,
      CMD_CFG,
      CMD_RFU
   } cmd_t;

   localparam logic [2:0] RCW_MRW = 3'b000;
   localparam logic [2:0] RCW_REF = 3'b001;
   localparam logic [2:0] RCW_PR  = 3'b010;
   localparam logic [2:0] RCW_RFU = 3'b011;
   localparam logic [2:0] RCW_WR  = 3'b100;
   localparam logic [2:0] RCW_RD  = 3'b101;
   localparam logic [2:0] RCW_CFG = 3'b110;
   localparam logic [2:0] RCW_NOP = 3'b111;

   // Commands that produce a command strobe and capture bg/ba/addr.
   function automatic logic is_strobe_cmd(cmd_t c);
      return c inside {CMD_ACT, CMD_MRW, CMD_REF, CMD_PR, CMD_PRA,
                       CMD_WR, CMD_WRA, CMD_RD, CMD_RDA, CMD_CFG};
   endfunction

endpackage

// File: rtl/cmd_truth_table.sv
// Combinational DDR4 command truth table: raw pins in, decoded command out.
// Power state and CKE qualification are applied by the caller.
module cmd_truth_table
   import ddr_cmd_pkg::*;
(
   input  logic cs_n,
   input  logic act_n,
   input  logic ras_n,
   input  logic cas_n,
   input  logic we_n,
   input  logic a10,
   output cmd_t cmd
);

   // Decode pins; A10 selects the auto-precharge / all-bank variants.
   always_comb begin
      cmd = CMD_DES;
      if (!cs_n) begin
         if (!act_n) begin
            cmd = CMD_ACT;
         end else begin
            case ({ras_n, cas_n, we_n})
               RCW_MRW: cmd = CMD_MRW;
               RCW_REF: cmd = CMD_REF;
               RCW_PR:  cmd = a10 ? CMD_PRA : CMD_PR;
               RCW_RFU: cmd = CMD_RFU;
               RCW_WR:  cmd = a10 ? CMD_WRA : CMD_WR;
               RCW_RD:  cmd = a10 ? CMD_RDA : CMD_RD;
               RCW_CFG: cmd = CMD_CFG;
               default: cmd = CMD_NOP;
            endcase
         end
      end
   end

endmodule

// File: rtl/cmd_decoder.sv
// DDR4 command decoder feeding TimingFSM: registers one-cycle command
// strobes, bg/ba/addr, CKE history and the power-state FSM.
//
// state    | meaning
// P_INIT   | after reset, pins ignored until cke goes high
// P_ACTIVE | normal operation, commands decoded
// P_PD     | power-down, left when cke rises (PDX + CKEH)
// P_SR     | self-refresh, left when cke rises (CKEH only)
module cmd_decoder
   import ddr_cmd_pkg::*;
#(
   parameter  int BGWIDTH   = 2,
   parameter  int BAWIDTH   = 2,
   parameter  int ADDRWIDTH = 17,
   localparam int BGW       = (BGWIDTH > 0) ? BGWIDTH : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cke,
   input  logic                 cs_n,
   input  logic                 act_n,
   input  logic                 ras_n,
   input  logic                 cas_n,
   input  logic                 we_n,
   input  logic [BGW-1:0]       bg_in,
   input  logic [BAWIDTH-1:0]   ba_in,
   input  logic [ADDRWIDTH-1:0] a_in,
   output logic [BGW-1:0]       bg,
   output logic [BAWIDTH-1:0]   ba,
   output logic [ADDRWIDTH-1:0] addr,
   output logic                 ACT,
   output logic                 BST,
   output logic                 CFG,
   output logic                 CKEH,
   output logic                 CKEL,
   output logic                 DPD,
   output logic                 DPDX,
   output logic                 MRR,
   output logic                 MRW,
   output logic                 PD,
   output logic                 PDX,
   output logic                 PR,
   output logic                 PRA,
   output logic                 RD,
   output logic                 RDA,
   output logic                 REF,
   output logic                 SRF,
   output logic                 WR,
   output logic                 WRA,
   output logic                 illegal_cmd,
   output logic [1:0]           pwr_state
);

   pwr_state_t           state;
   logic                 cke_q;
   cmd_t                 cmd;
   logic [ADDRWIDTH-1:0] act_addr;

   cmd_truth_table u_truth (
      .cs_n  (cs_n),
      .act_n (act_n),
      .ras_n (ras_n),
      .cas_n (cas_n),
      .we_n  (we_n),
      .a10   (a_in[10]),
      .cmd   (cmd)
   );

   // On ACT the ras_n/cas_n/we_n pins carry row bits A16..A14.
   generate
      if (ADDRWIDTH >= 17) begin : g_act_hi
         always_comb begin
            act_addr        = a_in;
            act_addr[16:14] = {ras_n, cas_n, we_n};
         end
      end else begin : g_act_lo
         assign act_addr = a_in;
      end
   endgenerate

   // Commands not present in DDR4.
   assign BST  = 1'b0;
   assign DPD  = 1'b0;
   assign DPDX = 1'b0;
   assign MRR  = 1'b0;

   assign pwr_state = state;

   // Power FSM, CKE history and registered strobes/address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= P_INIT;
         cke_q       <= 1'b0;
         bg          <= '0;
         ba          <= '0;
         addr        <= '0;
         ACT         <= 1'b0;
         CFG         <= 1'b0;
         CKEH        <= 1'b0;
         CKEL        <= 1'b0;
         MRW         <= 1'b0;
         PD          <= 1'b0;
         PDX         <= 1'b0;
         PR          <= 1'b0;
         PRA         <= 1'b0;
         RD          <= 1'b0;
         RDA         <= 1'b0;
         REF         <= 1'b0;
         SRF         <= 1'b0;
         WR          <= 1'b0;
         WRA         <= 1'b0;
         illegal_cmd <= 1'b0;
      end else begin
         cke_q       <= cke;
         ACT         <= 1'b0;
         CFG         <= 1'b0;
         CKEH        <= 1'b0;
         CKEL        <= 1'b0;
         MRW         <= 1'b0;
         PD          <= 1'b0;
         PDX         <= 1'b0;
         PR          <= 1'b0;
         PRA         <= 1'b0;
         RD          <= 1'b0;
         RDA         <= 1'b0;
         REF         <= 1'b0;
         SRF         <= 1'b0;
         WR          <= 1'b0;
         WRA         <= 1'b0;
         illegal_cmd <= 1'b0;

         case (state)
            P_INIT: begin
               if (cke) begin
                  CKEH  <= 1'b1;
                  state <= P_ACTIVE;
               end
            end

            P_ACTIVE: begin
               if (cke_q && !cke) begin
                  // The command sampled with the falling cke never executes.
                  CKEL <= 1'b1;
                  case (cmd)
                     CMD_REF: begin
                        SRF   <= 1'b1;
                        state <= P_SR;
                     end
                     CMD_NOP, CMD_DES: begin
                        PD    <= 1'b1;
                        state <= P_PD;
                     end
                     default: begin
                        illegal_cmd <= 1'b1;
                        state       <= P_PD;
                     end
                  endcase
               end else if (cke_q && cke) begin
                  case (cmd)
                     CMD_ACT: ACT         <= 1'b1;
                     CMD_MRW: MRW         <= 1'b1;
                     CMD_REF: REF         <= 1'b1;
                     CMD_PR:  PR          <= 1'b1;
                     CMD_PRA: PRA         <= 1'b1;
                     CMD_WR:  WR          <= 1'b1;
                     CMD_WRA: WRA         <= 1'b1;
                     CMD_RD:  RD          <= 1'b1;
                     CMD_RDA: RDA         <= 1'b1;
                     CMD_CFG: CFG         <= 1'b1;
                     CMD_RFU: illegal_cmd <= 1'b1;
                     default: ;
                  endcase
                  if (is_strobe_cmd(cmd)) begin
                     bg   <= bg_in;
                     ba   <= ba_in;
                     addr <= (cmd == CMD_ACT) ? act_addr : a_in;
                  end
               end
            end

            P_PD, P_SR: begin
               if (cmd != CMD_NOP && cmd != CMD_DES) begin
                  illegal_cmd <= 1'b1;
               end
               if (cke) begin
                  CKEH  <= 1'b1;
                  PDX   <= (state == P_PD);
                  state <= P_ACTIVE;
               end
            end

            default: state <= P_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_decoder.sv
// Randomised and directed bench for cmd_decoder with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_cmd_decoder;

   typedef struct packed {
      logic [18:0] stb;
      logic        ill;
      logic [1:0]  pwr;
      logic [1:0]  bg;
      logic [1:0]  ba;
      logic [16:0] addr;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cke = 1'b0, cs_n = 1'b1, act_n = 1'b1;
   logic        ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
   logic [1:0]  bg_in = '0, ba_in = '0;
   logic [16:0] a_in = '0;
   logic [1:0]  bg, ba;
   logic [16:0] addr;
   logic        ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX;
   logic        PR, PRA, RD, RDA, REF, SRF, WR, WRA, illegal_cmd;
   logic [1:0]  pwr_state;

   int vectors = 0;
   int miscompares = 0;

   obs_t  exp_q[$];
   string tag_q[$];

   // Strobe order matches the packed stb field, MSB first.
   string stb_names[19] = '{"ACT", "BST", "CFG", "CKEH", "CKEL", "DPD", "DPDX",
                            "MRR", "MRW", "PD", "PDX", "PR", "PRA", "RD", "RDA",
                            "REF", "SRF", "WR", "WRA"};

   // Reference model state: power state as an integer 0..3 and held address.
   int          m_pwr = 0;
   bit          m_prev = 0;
   bit [1:0]    m_bg = 0, m_ba = 0;
   bit [16:0]   m_addr = 0;

   cmd_decoder dut (
      .clk(clk), .reset(reset), .cke(cke), .cs_n(cs_n), .act_n(act_n),
      .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
      .bg_in(bg_in), .ba_in(ba_in), .a_in(a_in),
      .bg(bg), .ba(ba), .addr(addr),
      .ACT(ACT), .BST(BST), .CFG(CFG), .CKEH(CKEH), .CKEL(CKEL), .DPD(DPD),
      .DPDX(DPDX), .MRR(MRR), .MRW(MRW), .PD(PD), .PDX(PDX), .PR(PR),
      .PRA(PRA), .RD(RD), .RDA(RDA), .REF(REF), .SRF(SRF), .WR(WR),
      .WRA(WRA), .illegal_cmd(illegal_cmd), .pwr_state(pwr_state)
   );

   always #5 clk = ~clk;

   function automatic string decode(bit cs, bit an, bit [2:0] rcw, bit a10);
      if (cs) return "DES";
      if (!an) return "ACT";
      case (rcw)
         3'd0: return "MRW";
         3'd1: return "REF";
         3'd2: return a10 ? "PRA" : "PR";
         3'd3: return "RFU";
         3'd4: return a10 ? "WRA" : "WR";
         3'd5: return a10 ? "RDA" : "RD";
         3'd6: return "CFG";
         default: return "NOP";
      endcase
   endfunction

   function automatic logic [18:0] names_to_vec(string names[$]);
      logic [18:0] v = '0;
      foreach (names[k])
         for (int i = 0; i < 19; i++)
            if (stb_names[i] == names[k]) v[18-i] = 1'b1;
      return v;
   endfunction

   task automatic model_step(input bit rst, input bit k, input bit cs, input bit an,
                             input bit [2:0] rcw, input bit [1:0] g, input bit [1:0] b,
                             input bit [16:0] a, output obs_t e);
      string c;
      string fired[$];
      bit    ill = 0;
      e = '0;
      if (rst) begin
         m_pwr = 0; m_prev = 0; m_bg = 0; m_ba = 0; m_addr = 0;
         return;
      end
      c = decode(cs, an, rcw, a[10]);
      case (m_pwr)
         0: if (k) begin fired.push_back("CKEH"); m_pwr = 1; end
         1: begin
            if (m_prev && !k) begin
               fired.push_back("CKEL");
               if (c == "REF") begin fired.push_back("SRF"); m_pwr = 3; end
               else if (c == "NOP" || c == "DES") begin fired.push_back("PD"); m_pwr = 2; end
               else begin ill = 1; m_pwr = 2; end
            end else if (m_prev && k) begin
               if (c == "RFU") ill = 1;
               else if (c != "NOP" && c != "DES") begin
                  fired.push_back(c);
                  m_bg = g; m_ba = b;
                  m_addr = (c == "ACT") ? {rcw, a[13:0]} : a;
               end
            end
         end
         default: begin
            if (c != "NOP" && c != "DES") ill = 1;
            if (k) begin
               if (m_pwr == 2) fired.push_back("PDX");
               fired.push_back("CKEH");
               m_pwr = 1;
            end
         end
      endcase
      m_prev = k;
      e.stb  = names_to_vec(fired);
      e.ill  = ill;
      e.pwr  = 2'(m_pwr);
      e.bg   = m_bg;
      e.ba   = m_ba;
      e.addr = m_addr;
   endtask

   // Drives one cycle of pins and queues the response expected after the next edge.
   // rst_after asserts reset just after that edge, so the sampled command is lost.
   task automatic drive(input bit rst, input bit k, input bit cs, input bit an,
                        input bit [2:0] rcw, input bit [1:0] g, input bit [1:0] b,
                        input bit [16:0] a, input string tag, input bit rst_after);
      obs_t e;
      @(negedge clk);
      reset = rst;
      cke = k; cs_n = cs; act_n = an;
      {ras_n, cas_n, we_n} = rcw;
      bg_in = g; ba_in = b; a_in = a;
      model_step(rst | rst_after, k, cs, an, rcw, g, b, a, e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      if (rst_after) begin
         @(posedge clk);
         #1 reset = 1'b1;
      end
   endtask

   // Monitor: the DUT presents a full output word every cycle.
   obs_t  m_exp, m_got;
   string m_tag;
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            m_tag = tag_q.pop_front();
            m_got = {ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX, PR,
                     PRA, RD, RDA, REF, SRF, WR, WRA, illegal_cmd, pwr_state,
                     bg, ba, addr};
            vectors++;
            if (m_got !== m_exp) begin
               miscompares++;
               $display("FAIL %s @%0t: got stb=%b ill=%b pwr=%0d bg=%0d ba=%0d addr=%h, expected stb=%b ill=%b pwr=%0d bg=%0d ba=%0d addr=%h",
                        m_tag, $time, m_got.stb, m_got.ill, m_got.pwr, m_got.bg, m_got.ba, m_got.addr,
                        m_exp.stb, m_exp.ill, m_exp.pwr, m_exp.bg, m_exp.ba, m_exp.addr);
            end
         end
      end
   end

   initial begin
      int drain;
      drive(1, 0, 1, 1, 3'd7, 0, 0, 17'h0, "reset", 0);
      drive(1, 0, 1, 1, 3'd7, 0, 0, 17'h0, "reset", 0);
      drive(0, 0, 0, 0, 3'd0, 1, 1, 17'h1234, "init_ignore", 0);
      drive(0, 1, 1, 1, 3'd7, 0, 0, 17'h0, "ckeh_init", 0);
      drive(0, 1, 0, 0, 3'd0, 1, 1, 17'h00A5, "act", 0);
      drive(0, 1, 1, 1, 3'd7, 0, 0, 17'h0, "des_hold", 0);
      drive(0, 1, 0, 1, 3'd4, 2, 3, 17'h0123, "wr", 0);
      drive(0, 1, 0, 1, 3'd4, 3, 2, 17'h0523, "wra", 0);
      drive(0, 1, 0, 1, 3'd5, 1, 0, 17'h0321, "rd", 0);
      drive(0, 1, 0, 1, 3'd5, 0, 1, 17'h0721, "rda", 0);
      drive(0, 1, 0, 1, 3'd2, 2, 2, 17'h0400, "pra", 0);
      drive(0, 1, 0, 0, 3'd5, 3, 3, 17'h1FFFF, "act_a16_14", 0);
      drive(0, 0, 0, 1, 3'd1, 1, 1, 17'h0055, "ref_srf", 0);
      drive(0, 0, 1, 1, 3'd7, 0, 0, 17'h0, "sr_hold", 0);
      drive(0, 1, 1, 1, 3'd7, 0, 0, 17'h0, "sr_exit", 0);
      drive(0, 0, 0, 1, 3'd7, 0, 0, 17'h0, "nop_pd", 0);
      drive(0, 0, 0, 1, 3'd5, 1, 2, 17'h0777, "rd_in_pd", 0);
      drive(0, 1, 1, 1, 3'd7, 0, 0, 17'h0, "pd_exit", 0);
      drive(0, 1, 0, 1, 3'd3, 3, 3, 17'h0AAA, "rfu", 0);
      drive(0, 1, 1, 0, 3'd0, 2, 1, 17'h0BBB, "deselect_act", 0);
      drive(0, 0, 0, 0, 3'd0, 1, 1, 17'h0CCC, "act_cke_fall", 0);
      drive(0, 1, 1, 1, 3'd7, 0, 0, 17'h0, "pd_exit2", 0);
      drive(0, 1, 0, 0, 3'd1, 3, 2, 17'h0F0F, "act_then_reset", 1);
      drive(1, 1, 1, 1, 3'd7, 0, 0, 17'h0, "reset_mid", 0);
      drive(0, 0, 1, 1, 3'd7, 0, 0, 17'h0, "post_reset_init", 0);
      drive(0, 1, 1, 1, 3'd7, 0, 0, 17'h0, "post_reset_ckeh", 0);

      for (int i = 0; i < 600; i++) begin
         bit       r, k, cs, an;
         bit [2:0] rcw;
         r   = ($urandom_range(0, 199) == 0);
         k   = ($urandom_range(0, 99) < 88);
         cs  = ($urandom_range(0, 99) < 30);
         an  = ($urandom_range(0, 99) < 80);
         rcw = 3'($urandom_range(0, 7));
         drive(r, k, cs, an, rcw, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               17'($urandom_range(0, 17'h1FFFF)), "random", 0);
      end

      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(posedge clk);
         drain++;
      end
      #3;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d responses still pending, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
